// File: rtl/i2s_transmitter.sv
// I2S transmitter: serializes stereo PCM pairs with a self-generated bclk/lrclk.
// Define I2S_TX_REPEAT_ON_UNDERRUN_EN to re-send the last pair on underrun (default: zero fill).
module i2s_transmitter #(
    parameter int unsigned data_width = 16,
    parameter int unsigned slot_width = 32,
    parameter int unsigned bclk_div   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [data_width-1:0] left_in,
    input  logic [data_width-1:0] right_in,
    output logic                  ready,
    output logic                  underrun,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata
);

    localparam int unsigned FRAME_LEN = 2 * slot_width;
    localparam int unsigned POS_W     = $clog2(FRAME_LEN);
    localparam int unsigned DIV_W     = (bclk_div > 1) ? $clog2(bclk_div) : 1;
    localparam int unsigned IDX_W     = (data_width > 1) ? $clog2(data_width) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclk_div - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] SLOT     = POS_W'(slot_width);
    localparam logic [POS_W-1:0] DW       = POS_W'(data_width);
    localparam logic [POS_W-1:0] LR_LO    = POS_W'(slot_width - 1);
    localparam logic [POS_W-1:0] LR_HI    = POS_W'(FRAME_LEN - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(data_width - 1);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic                  underrun_q, underrun_d;
    logic                  full_q, full_d;
    logic                  ready_q;
    logic [data_width-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [data_width-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [data_width-1:0] fill_l, fill_r;
    logic [data_width-1:0] slot_word;
    logic [POS_W-1:0]      slot_pos;
    logic                  tick, fall, frame_load;

    assign tick       = (div_cnt_q == DIV_LAST);
    assign fall       = tick && bclk_q;
    assign frame_load = fall && (pos_q == POS_LAST);

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [data_width-1:0] last_l_q, last_r_q;

    // Remembers whatever pair went out in the current frame, fill included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_l_q <= '0;
            last_r_q <= '0;
        end else if (frame_load) begin
            last_l_q <= tx_l_d;
            last_r_q <= tx_r_d;
        end
    end

    assign fill_l = last_l_q;
    assign fill_r = last_r_q;
`else
    assign fill_l = '0;
    assign fill_r = '0;
`endif

    always_comb begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
        bclk_d     = bclk_q;
        pos_d      = pos_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        full_d     = full_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        slot_pos   = '0;
        slot_word  = '0;

        if (tick) begin
            div_cnt_d = '0;
            bclk_d    = !bclk_q;
        end

        // Frame load drains the holding register, bypasses a same-cycle pair, or fills.
        if (frame_load) begin
            if (full_q) begin
                tx_l_d = hold_l_q;
                tx_r_d = hold_r_q;
                full_d = 1'b0;
            end else if (enable) begin
                tx_l_d = left_in;
                tx_r_d = right_in;
            end else begin
                tx_l_d     = fill_l;
                tx_r_d     = fill_r;
                underrun_d = 1'b1;
            end
        end else if (enable && !full_q) begin
            hold_l_d = left_in;
            hold_r_d = right_in;
            full_d   = 1'b1;
        end

        // lrclk and sdata follow the new position so they change on bclk falling edges.
        if (fall) begin
            pos_d   = frame_load ? '0 : pos_q + POS_W'(1);
            lrclk_d = (pos_d >= LR_LO) && (pos_d <= LR_HI);
            if (pos_d >= SLOT) begin
                slot_pos  = pos_d - SLOT;
                slot_word = tx_r_d;
            end else begin
                slot_pos  = pos_d;
                slot_word = tx_l_d;
            end
            sdata_d = (slot_pos < DW) ? slot_word[IDX_LAST - IDX_W'(slot_pos)] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            pos_q      <= POS_LAST;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            tx_l_q     <= '0;
            tx_r_q     <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pos_q      <= pos_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            full_q     <= full_d;
            ready_q    <= !full_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
        end
    end

    assign ready    = ready_q;
    assign underrun = underrun_q;
    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: frame-by-frame vector table plus hand sequences.
module tb_i2s_transmitter;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        ready;
    logic        underrun;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    always #5 clk = ~clk;

    i2s_transmitter dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .left_in  (left_in),
        .right_in (right_in),
        .ready    (ready),
        .underrun (underrun),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata)
    );

    // One frame of expected output plus up to two enable windows (clock-edge ranges).
    typedef struct {
        bit          rst_before;
        int          frame;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        int          exp_ur;
        int          o1_from;
        int          o1_to;
        logic [15:0] o1_l;
        logic [15:0] o1_r;
        int          o2_from;
        int          o2_to;
        logic [15:0] o2_l;
        logic [15:0] o2_r;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ecnt     = 0;
    vec_t tbl [11];

    function automatic vec_t mk(bit rb, int f, logic [15:0] el, logic [15:0] er, int eu,
                                int a1, int b1, logic [15:0] l1, logic [15:0] r1,
                                int a2, int b2, logic [15:0] l2, logic [15:0] r2);
        vec_t v;
        v.rst_before = rb; v.frame = f; v.exp_l = el; v.exp_r = er; v.exp_ur = eu;
        v.o1_from = a1; v.o1_to = b1; v.o1_l = l1; v.o1_r = r1;
        v.o2_from = a2; v.o2_to = b2; v.o2_l = l2; v.o2_r = r2;
        return v;
    endfunction

    function automatic logic [63:0] exp_frame(logic [15:0] l, logic [15:0] r);
        logic [63:0] w;
        w = '0;
        w[63:48] = l;
        w[31:16] = r;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    // Sets up inputs for the next clock edge (ecnt+1).
    task automatic drive(input vec_t v);
        int e;
        e = ecnt + 1;
        if (e >= v.o1_from && e <= v.o1_to) begin
            enable = 1'b1; left_in = v.o1_l; right_in = v.o1_r;
        end else if (e >= v.o2_from && e <= v.o2_to) begin
            enable = 1'b1; left_in = v.o2_l; right_in = v.o2_r;
        end else begin
            enable = 1'b0; left_in = 16'hDEAD; right_in = 16'hBEEF;
        end
    endtask

    task automatic do_reset();
        enable = 1'b0; left_in = 16'hDEAD; right_in = 16'hBEEF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 64'({bclk, lrclk, sdata, ready, underrun}), 64'(5'b00010));
        @(negedge clk);
        rst  = 1'b0;
        ecnt = 0;
    endtask

    // Runs through the given frame, capturing sdata/lrclk at every fall event.
    task automatic run_frame(input vec_t v, input string tag);
        logic [63:0] sd, lr, lr_exp;
        int ur, bclk_err, last;
        sd = '0; lr = '0; lr_exp = '0; ur = 0; bclk_err = 0;
        last = 3 + 256 * (v.frame + 1);
        for (int p = 31; p <= 62; p++) lr_exp[63-p] = 1'b1;
        if (ecnt == 0) drive(v);
        while (ecnt < last) begin
            step();
            if (underrun === 1'b1) ur++;
            if (bclk !== 1'((ecnt >> 1) & 1)) bclk_err++;
            if (ecnt >= 4 && ((ecnt - 4) % 4) == 0) begin
                int p;
                p = (ecnt - 4) / 4 - 64 * v.frame;
                if (p >= 0 && p < 64) begin
                    sd[63-p] = sdata;
                    lr[63-p] = lrclk;
                end
            end
            drive(v);
        end
        check({tag, " sdata"}, sd, exp_frame(v.exp_l, v.exp_r));
        check({tag, " lrclk"}, lr, lr_exp);
        check({tag, " underrun"}, 64'(ur), 64'(v.exp_ur));
        check({tag, " bclk"}, 64'(bclk_err), 64'(0));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; left_in = '0; right_in = '0;

        // Row 0-6: idle frame, mid-frame offer, load-cycle bypass, starvation after 7FFF.
        tbl[0]  = mk(1, 0, 16'h0000, 16'h0000, 1, 54, 54, 16'hA5C3, 16'h8001, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 16'hA5C3, 16'h8001, 0, 516, 516, 16'h1234, 16'hFEDC, 0, 0, 0, 0);
        tbl[2]  = mk(0, 2, 16'h1234, 16'hFEDC, 0, 600, 600, 16'h7FFF, 16'h4000, 0, 0, 0, 0);
        tbl[3]  = mk(0, 3, 16'h7FFF, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 4, REP ? 16'h7FFF : 16'h0000, REP ? 16'h4000 : 16'h0000, 1,
                     1100, 1100, 16'h0001, 16'h8000, 0, 0, 0, 0);
        tbl[5]  = mk(0, 5, 16'h0001, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 6, REP ? 16'h0001 : 16'h0000, REP ? 16'h8000 : 16'h0000, 1,
                     0, 0, 0, 0, 0, 0, 0, 0);
        // Row 7-10: back-to-back offers; second waits for the load, third is dropped.
        tbl[7]  = mk(1, 0, 16'h0000, 16'h0000, 1, 50, 50, 16'h1111, 16'h2222,
                     51, 260, 16'h3333, 16'h4444);
        tbl[8]  = mk(0, 1, 16'h1111, 16'h2222, 0, 261, 261, 16'h3333, 16'h4444,
                     300, 300, 16'hC0DE, 16'hF00D);
        tbl[9]  = mk(0, 2, 16'h3333, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 3, REP ? 16'h3333 : 16'h0000, REP ? 16'h4444 : 16'h0000, 1,
                     0, 0, 0, 0, 0, 0, 0, 0);

        // Pair offered on the first edge after reset.
        do_reset();
        enable = 1'b1; left_in = 16'hA5C3; right_in = 16'h8001;
        step();
        enable = 1'b0; left_in = 16'hDEAD; right_in = 16'hBEEF;
        check("ready after accept", 64'(ready), 64'(0));
        step();
        check("first bclk rise", 64'({bclk, ready}), 64'(2'b10));
        step();
        check("ready held low", 64'(ready), 64'(0));
        step();
        check("first frame load", 64'({ready, sdata, bclk, lrclk, underrun}), 64'(5'b11000));

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst_before) do_reset();
            run_frame(tbl[i], $sformatf("row%0d", i));
        end

        // Reset at pos 10 with the holding register full.
        do_reset();
        enable = 1'b1; left_in = 16'hFFFF; right_in = 16'hFFFF;
        step();
        enable = 1'b0; left_in = 16'hDEAD; right_in = 16'hBEEF;
        while (ecnt < 5) step();
        enable = 1'b1; left_in = 16'h5A5A; right_in = 16'hA5A5;
        step();
        enable = 1'b0; left_in = 16'hDEAD; right_in = 16'hBEEF;
        while (ecnt < 46) step();
        check("pre-reset sdata/ready/bclk", 64'({sdata, ready, bclk}), 64'(3'b101));
        rst = 1'b1;
        #1;
        check("mid-frame reset outputs", 64'({bclk, lrclk, sdata, ready, underrun}), 64'(5'b00010));
        @(negedge clk);
        rst  = 1'b0;
        ecnt = 0;
        run_frame(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0), "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
